// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and a
// width helper for sizing the bit counter.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Ceiling log2; returns 0 for value <= 1, so callers clamp to a minimum width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus between the serial adder
// and the surrounding datapath.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell built from two half adders and an OR of their
// carries; purely combinational.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b;
    assign c_out = a & b;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(x),  .b(y),    .s(s0), .c_out(c0));
    half_adder u_ha1 (.a(s0), .b(c_in), .s(s),  .c_out(c1));

    // At most one of the two half-adder carries can be set, so OR is exact.
    assign c_out = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through a single
// full adder cell, one bit per clock, with a start/busy/done handshake.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_sh_q;
    logic [WIDTH-1:0]   res_sh_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               fa_s;
    logic               fa_c;

    full_adder u_fa (
        .x     (a_sh_q[0]),
        .y     (b_sh_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // New result bit enters at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_sh_d = fa_s;
        end else begin : g_res_wn
            assign res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    res_sh_q <= res_sh_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= res_sh_d;
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: WIDTH=8 operations,
// busy/back-to-back handling, mid-run reset, and a WIDTH=1 instance.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns at the falling edge after the accepting edge.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = cin;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    // Counts falling edges with busy high (bounded), then checks the done cycle.
    task automatic finish8(input string tag, input int exp_busy,
                           input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        n = 0;
        while (if8.busy === 1'b1 && n < 40) begin
            n = n + 1;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, exp_busy);
        check({tag, "_done"}, {31'd0, if8.done}, 32'd1);
        check({tag, "_sum"}, {24'd0, if8.sum}, {24'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, if8.cout}, {31'd0, exp_cout});
    endtask

    initial begin
        int dones;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, if8.busy}, 32'd0);
        check("rst_done", {31'd0, if8.done}, 32'd0);
        check("rst_sum",  {24'd0, if8.sum},  32'd0);
        check("rst_cout", {31'd0, if8.cout}, 32'd0);
        check("rst_w1_sum", {31'd0, if1.sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch8(8'h00, 8'h00, 1'b0);
        finish8("zero", 8, 8'h00, 1'b0);

        launch8(8'hFF, 8'h01, 1'b0);
        finish8("ff_01", 8, 8'h00, 1'b1);

        launch8(8'hA5, 8'h5A, 1'b1);
        finish8("a5_5a_c", 8, 8'h00, 1'b1);

        // A start during RUN with new operands must be ignored.
        launch8(8'h3C, 8'h42, 1'b0);
        repeat (2) @(negedge clk);
        if8.start = 1'b1;
        if8.a     = 8'h10;
        if8.b     = 8'h01;
        @(negedge clk);
        if8.start = 1'b0;
        finish8("3c_42", 5, 8'h7E, 1'b0);

        // Back-to-back: start raised during the done cycle.
        if8.start = 1'b1;
        if8.a     = 8'h80;
        if8.b     = 8'h80;
        if8.cin   = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        check("b2b_done_pulse", {31'd0, if8.done}, 32'd0);
        check("b2b_busy", {31'd0, if8.busy}, 32'd1);
        check("b2b_sum_held", {24'd0, if8.sum}, 32'h7E);
        finish8("80_80", 8, 8'h00, 1'b1);
        @(negedge clk);
        check("idle_done", {31'd0, if8.done}, 32'd0);
        check("idle_busy", {31'd0, if8.busy}, 32'd0);
        check("idle_sum", {24'd0, if8.sum}, 32'h00);

        launch8(8'hF0, 8'h20, 1'b0);
        finish8("f0_20", 8, 8'h10, 1'b1);

        // Asynchronous reset in the fourth RUN cycle aborts the operation.
        launch8(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy_before", {31'd0, if8.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, if8.busy}, 32'd0);
        check("mid_rst_sum",  {24'd0, if8.sum},  32'd0);
        check("mid_rst_cout", {31'd0, if8.cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done === 1'b1) dones = dones + 1;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_idle_busy", {31'd0, if8.busy}, 32'd0);

        // Minimum width instance.
        @(negedge clk);
        if1.start = 1'b1;
        if1.a     = 1'b1;
        if1.b     = 1'b1;
        if1.cin   = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        check("w1_busy", {31'd0, if1.busy}, 32'd1);
        check("w1_done_early", {31'd0, if1.done}, 32'd0);
        @(negedge clk);
        check("w1_done", {31'd0, if1.done}, 32'd1);
        check("w1_busy_off", {31'd0, if1.busy}, 32'd0);
        check("w1_sum", {31'd0, if1.sum}, 32'd1);
        check("w1_cout", {31'd0, if1.cout}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
